// File: rtl/pcs_tx_gearbox.sv
// pcs_tx_gearbox: turns the 66b encoder/scrambler block stream into a continuous DATA_W-bit
// line stream. Sync headers pile up in a residue buffer that is drained once per 33*CNT_N cycles.
module pcs_tx_gearbox #(
    parameter int DATA_W  = 64,
    parameter int BLOCK_W = 64,
    parameter int CNT_N   = BLOCK_W / DATA_W,
    parameter int SEQ_W   = $clog2(33 * CNT_N)
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              head_v_i,
    input  logic [1:0]        sync_head_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              ready_o,
    output logic              data_v_o,
    output logic [DATA_W-1:0] data_o,
    output logic [SEQ_W-1:0]  seq_o
);
    localparam int                BUF_W     = 130;
    localparam int                PART_W    = (CNT_N > 1) ? $clog2(CNT_N) : 1;
    localparam logic [SEQ_W-1:0]  STALL_SEQ = SEQ_W'(32 * CNT_N);
    localparam logic [SEQ_W-1:0]  LAST_SEQ  = SEQ_W'(33 * CNT_N - 1);
    localparam logic [PART_W-1:0] LAST_PART = PART_W'(CNT_N - 1);
    localparam logic [6:0]        W_BITS    = 7'(DATA_W);

    logic [SEQ_W-1:0]  seq;
    logic [6:0]        r;
    logic [BUF_W-1:0]  residue;
    logic [BUF_W-1:0]  word;
    logic [BUF_W-1:0]  cat;
    logic [PART_W-1:0] part;

    assign ready_o = (seq < STALL_SEQ);
    assign seq_o   = seq;

    // Residue bits at and above r are always zero, so OR-ing the shifted word yields {w, residue[r-1:0]}.
    always_comb begin
        word = '0;
        if (head_v_i) begin
            word = BUF_W'({data_i, sync_head_i});
        end else begin
            word = BUF_W'(data_i);
        end
        cat = residue | (word << r);
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            seq      <= '0;
            r        <= '0;
            residue  <= '0;
            part     <= '0;
            data_o   <= '0;
            data_v_o <= 1'b0;
        end else begin
            seq      <= (seq == LAST_SEQ) ? '0 : seq + 1'b1;
            data_v_o <= 1'b1;
            if (ready_o) begin
                data_o  <= cat[DATA_W-1:0];
                residue <= cat >> DATA_W;
                part    <= (part == LAST_PART) ? '0 : part + 1'b1;
                if (head_v_i) begin
                    r <= r + 7'd2;
                end
            end else begin
                data_o  <= residue[DATA_W-1:0];
                residue <= residue >> DATA_W;
                r       <= r - W_BITS;
            end
        end
    end

    // Upstream must mark exactly every CNT_N-th accepted word as a block head.
    a_head_position: assert property (@(posedge clk) disable iff (!nreset)
        ready_o |-> (head_v_i == (part == '0)));

    a_r_max: assert property (@(posedge clk) disable iff (!nreset) r <= 7'd64);

    a_r_zero_at_wrap: assert property (@(posedge clk) disable iff (!nreset)
        (seq == '0) |-> (r == '0));

    a_stall_start: assert property (@(posedge clk) disable iff (!nreset)
        $fell(ready_o) |-> (seq == STALL_SEQ));

    a_stall_end: assert property (@(posedge clk) disable iff (!nreset)
        $rose(ready_o) |-> (seq == '0));

    a_no_x: assert property (@(posedge clk) disable iff (!nreset)
        !$isunknown({ready_o, data_v_o, data_o, seq_o}));

endmodule

// File: tb/tb_pcs_tx_gearbox.sv
// tb_pcs_tx_gearbox: drives 66b block streams into a 64b and a 16b gearbox and compares every
// line word against a bit-serial reference queue fed at stimulus time.
module tb_pcs_tx_gearbox;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        nrst64, nrst16;
    logic        hv64, hv16;
    logic [1:0]  sh64, sh16;
    logic [63:0] din64;
    logic [15:0] din16;
    logic        rdy64, rdy16, dv64, dv16;
    logic [63:0] dout64;
    logic [15:0] dout16;
    logic [5:0]  seq64;
    logic [7:0]  seq16;

    pcs_tx_gearbox #(.DATA_W(64)) dut64 (
        .clk(clk), .nreset(nrst64), .head_v_i(hv64), .sync_head_i(sh64), .data_i(din64),
        .ready_o(rdy64), .data_v_o(dv64), .data_o(dout64), .seq_o(seq64)
    );

    pcs_tx_gearbox #(.DATA_W(16)) dut16 (
        .clk(clk), .nreset(nrst16), .head_v_i(hv16), .sync_head_i(sh16), .data_i(din16),
        .ready_o(rdy16), .data_v_o(dv16), .data_o(dout16), .seq_o(seq16)
    );

    int cur = 0;
    int w, cnt_n, period;
    int cyc, part, blk;
    int checks, errors;
    bit          ser [$];
    logic [63:0] expq [$];

    function automatic logic [63:0] cur_dout();
        return (cur == 1) ? {48'd0, dout16} : dout64;
    endfunction

    function automatic logic cur_dv();
        return (cur == 1) ? dv16 : dv64;
    endfunction

    function automatic logic cur_rdy();
        return (cur == 1) ? rdy16 : rdy64;
    endfunction

    function automatic logic cur_nrst();
        return (cur == 1) ? nrst16 : nrst64;
    endfunction

    function automatic logic [63:0] cur_seq();
        return (cur == 1) ? 64'(seq16) : 64'(seq64);
    endfunction

    function automatic logic [63:0] payload(int b, int p);
        if (b == 0 && p == 0) return 64'h0123456789ABCDEF;
        return {b[15:0], 8'h5A, p[7:0], ~b[15:0], b[7:0], p[7:0]};
    endfunction

    task automatic select_dut(int idx);
        cur    = idx;
        w      = (idx == 1) ? 16 : 64;
        cnt_n  = 64 / w;
        period = 33 * cnt_n;
    endtask

    task automatic set_inputs(logic h, logic [1:0] s, logic [63:0] d);
        if (cur == 1) begin
            hv16 = h; sh16 = s; din16 = d[15:0];
        end else begin
            hv64 = h; sh64 = s; din64 = d;
        end
    endtask

    task automatic set_nrst(logic v);
        if (cur == 1) nrst16 = v;
        else nrst64 = v;
    endtask

    task automatic check_output(string name, logic [63:0] actual, logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Hold reset with random inputs, check the reset outputs, then release just after an edge.
    task automatic hold_reset(int n);
        set_nrst(1'b0);
        expq.delete();
        ser.delete();
        repeat (n) begin
            set_inputs(1'($urandom), 2'($urandom), {$urandom, $urandom});
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check_output("reset data_o", cur_dout(), 64'd0);
        check_output("reset data_v_o", 64'(cur_dv()), 64'd0);
        check_output("reset ready_o", 64'(cur_rdy()), 64'd1);
        check_output("reset seq_o", cur_seq(), 64'd0);
        @(posedge clk);
        #1;
        set_inputs(1'b0, 2'b00, 64'd0);
        set_nrst(1'b1);
        cyc  = 0;
        part = 0;
        blk  = 0;
    endtask

    // mode 0: all data headers; mode 1: ctrl/data headers alternating per block.
    task automatic apply_stimulus(int ncyc, int mode);
        logic [63:0] d;
        logic [63:0] e;
        logic [1:0]  s;
        logic        h;
        repeat (ncyc) begin
            check_output("ready_o", 64'(cur_rdy()), 64'((cyc % period) < 32 * cnt_n));
            check_output("seq_o", cur_seq(), 64'(cyc % period));
            if ((cyc % period) < 32 * cnt_n) begin
                h = (part == 0);
                s = 2'b00;
                if (h) begin
                    s = (mode == 1 && blk[0]) ? 2'b10 : 2'b01;
                    ser.push_back(s[0]);
                    ser.push_back(s[1]);
                    blk++;
                end
                d = payload(blk - 1, part);
                for (int i = 0; i < w; i++) ser.push_back(d[i]);
                set_inputs(h, s, d);
                part = (part + 1) % cnt_n;
            end else begin
                set_inputs(1'b1, 2'b11, {$urandom, $urandom});
            end
            e = '0;
            for (int i = 0; i < w; i++) e[i] = ser.pop_front();
            expq.push_back(e);
            cyc++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        @(negedge clk);
        #1;
        check_output("queue empty", 64'(expq.size()), 64'd0);
    endtask

    // Monitor: one expected word per valid output; the queue runs one entry ahead of the DUT.
    initial begin
        forever begin
            @(negedge clk);
            if (cur_nrst()) begin
                if (cur_dv()) begin
                    if (expq.size() == 0) check_output("data_v_o idle", 64'(cur_dv()), 64'd0);
                    else check_output("data_o", cur_dout(), expq.pop_front());
                end else if (expq.size() > 1) begin
                    check_output("data_v_o", 64'(cur_dv()), 64'd1);
                end
            end
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        nrst64 = 1'b0; nrst16 = 1'b0;
        hv64 = 1'b0; hv16 = 1'b0; sh64 = 2'b00; sh16 = 2'b00; din64 = '0; din16 = '0;
        select_dut(0);
        @(posedge clk);
        #1;

        hold_reset(3);
        apply_stimulus(1, 0);
        check_output("first data_o", dout64, 64'h048D159E26AF37BD);
        check_output("first data_v_o", 64'(dv64), 64'd1);
        check_output("first r", 64'(dut64.r), 64'd2);
        check_output("first residue", 64'(dut64.residue[1:0]), 64'd0);
        apply_stimulus(65, 0);
        apply_stimulus(99, 1);
        drain();

        hold_reset(2);
        apply_stimulus(17, 0);
        check_output("mid-period r", 64'(dut64.r), 64'd34);
        hold_reset(2);
        check_output("post-reset r", 64'(dut64.r), 64'd0);
        check_output("post-reset residue", 64'(dut64.residue != '0), 64'd0);
        apply_stimulus(66, 0);
        drain();

        nrst64 = 1'b0;
        select_dut(1);
        hold_reset(2);
        apply_stimulus(264, 1);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
